// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the two-port RAM arbiter.
package mem_arbiter_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 32;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way grant picker: round-robin on ~last, or fixed port-0 priority.
module rr_pick2
    import mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    logic [1:0] eligible;

    always_comb begin
        eligible = req & ~mask;
        valid    = |eligible;
        winner   = P_CPU;
        case (eligible)
            2'b01:   winner = P_CPU;
            2'b10:   winner = P_DMA;
            2'b11:   winner = (FIXED_PRI != 0) ? P_CPU : ~last;
            default: winner = P_CPU;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port RAM: IDLE -> ACCESS -> RESP, all outputs registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int FIXED_PRI = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] mem_dado,
    output logic [AW-1:0] mem_end,
    output logic          mem_write,
    input  logic [DW-1:0] mem_saida
);

    state_t        state;
    logic          owner;
    logic          last;
    logic [1:0]    mask;
    logic          grant_valid;
    logic          grant_port;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_we;

    // The owner still holds req during its RESP cycle, so it sits out that one decision.
    always_comb begin
        mask      = (state == RESP) ? port_onehot(owner) : 2'b00;
        sel_addr  = (grant_port == P_DMA) ? addr1  : addr0;
        sel_wdata = (grant_port == P_DMA) ? wdata1 : wdata0;
        sel_we    = (grant_port == P_DMA) ? we1    : we0;
    end

    rr_pick2 #(
        .FIXED_PRI(FIXED_PRI)
    ) u_pick (
        .req   ({req1, req0}),
        .mask  (mask),
        .last  (last),
        .valid (grant_valid),
        .winner(grant_port)
    );

    // RAM reads on the mid-cycle negedge, so mem_saida is valid at the end of ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= P_CPU;
            last      <= 1'b1;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_dado  <= '0;
            mem_end   <= '0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state     <= ACCESS;
                        owner     <= grant_port;
                        last      <= grant_port;
                        mem_end   <= sel_addr;
                        mem_dado  <= sel_wdata;
                        mem_write <= sel_we;
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    mem_write <= 1'b0;
                    if (owner == P_DMA) begin
                        ack1 <= 1'b1;
                        if (!mem_write) rdata1 <= mem_saida;
                    end else begin
                        ack0 <= 1'b1;
                        if (!mem_write) rdata0 <= mem_saida;
                    end
                end
                RESP: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (grant_valid) begin
                        state     <= ACCESS;
                        owner     <= grant_port;
                        last      <= grant_port;
                        mem_end   <= sel_addr;
                        mem_dado  <= sel_wdata;
                        mem_write <= sel_we;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ack0      <= 1'b0;
                    ack1      <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin and fixed-priority instances, each with its own RAM model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;

    logic        req0, req1, we0, we1;
    logic [9:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_dado;
    logic [9:0]  mem_end;
    logic        mem_write;
    logic [31:0] mem_saida;

    logic        fp_req0, fp_req1, fp_we0, fp_we1;
    logic [9:0]  fp_addr0, fp_addr1;
    logic [31:0] fp_wdata0, fp_wdata1;
    logic        fp_ack0, fp_ack1;
    logic [31:0] fp_rdata0, fp_rdata1;
    logic [31:0] fp_mem_dado;
    logic [9:0]  fp_mem_end;
    logic        fp_mem_write;
    logic [31:0] fp_mem_saida;

    logic [31:0] ram    [1024];
    logic [31:0] fp_ram [1024];

    int vectors;
    int miscompares;

    mem_arbiter #(.AW(10), .DW(32), .FIXED_PRI(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_dado(mem_dado), .mem_end(mem_end), .mem_write(mem_write),
        .mem_saida(mem_saida)
    );

    mem_arbiter #(.AW(10), .DW(32), .FIXED_PRI(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(fp_req0), .req1(fp_req1), .we0(fp_we0), .we1(fp_we1),
        .addr0(fp_addr0), .addr1(fp_addr1), .wdata0(fp_wdata0), .wdata1(fp_wdata1),
        .ack0(fp_ack0), .ack1(fp_ack1), .rdata0(fp_rdata0), .rdata1(fp_rdata1),
        .mem_dado(fp_mem_dado), .mem_end(fp_mem_end), .mem_write(fp_mem_write),
        .mem_saida(fp_mem_saida)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: write on posedge, read on negedge, both on the shared clock.
    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = 32'hA000_0000 + 32'(i);
            fp_ram[i] = 32'hA000_0000 + 32'(i);
        end
    end

    always @(posedge clk) begin
        if (mem_write) ram[mem_end] = mem_dado;
        if (fp_mem_write) fp_ram[fp_mem_end] = fp_mem_dado;
    end

    always @(negedge clk) begin
        mem_saida    = ram[mem_end];
        fp_mem_saida = fp_ram[fp_mem_end];
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack0: got %b expected 0", ack0); end
        vectors++; if (ack1 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack1: got %b expected 0", ack1); end
        vectors++; if (rdata0 !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata0: got %h expected 0", rdata0); end
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata1: got %h expected 0", rdata1); end
        vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_write: got %b expected 0", mem_write); end
        vectors++; if (mem_end !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_mem_end: got %0d expected 0", mem_end); end
        vectors++; if (mem_dado !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_dado: got %h expected 0", mem_dado); end

        rst_n  = 1'b1;
        req0   = 1'b1;
        we0    = 1'b1;
        addr0  = 10'd5;
        wdata0 = 32'hBAD0_0005;
        @(posedge clk);
        #1;
        vectors++; if (mem_write !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_access_write: got %b expected 1", mem_write); end
        vectors++; if (mem_end !== 10'd5) begin miscompares++; $display("[TB] FAIL reset_access_addr: got %0d expected 5", mem_end); end

        #2 rst_n = 1'b0;
        #1;
        vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_async_write: got %b expected 0", mem_write); end
        vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_async_ack0: got %b expected 0", ack0); end
        vectors++; if (ack1 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_async_ack1: got %b expected 0", ack1); end
        vectors++; if (mem_end !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_async_mem_end: got %0d expected 0", mem_end); end
        req0   = 1'b0;
        we0    = 1'b0;
        addr0  = 10'd0;
        wdata0 = 32'h0;

        @(posedge clk);
        #1;
        vectors++; if (ram[5] !== 32'hA000_0005) begin miscompares++; $display("[TB] FAIL reset_ram5_dropped: got %h expected a0000005", ram[5]); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_release_ack0: got %b expected 0", ack0); end
        vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_release_write: got %b expected 0", mem_write); end
        vectors++; if (ram[5] !== 32'hA000_0005) begin miscompares++; $display("[TB] FAIL reset_ram5_after: got %h expected a0000005", ram[5]); end
    endtask

    task automatic test_simultaneous();
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd2;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd3;
        @(posedge clk); #1;
        vectors++; if (mem_end !== 10'd2) begin miscompares++; $display("[TB] FAIL simul_first_grant: got addr %0d expected 2", mem_end); end
        vectors++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_access_acks: got %b%b expected 00", ack1, ack0); end
        @(posedge clk); #1;
        vectors++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_ack0: got ack1/ack0 %b%b expected 01", ack1, ack0); end
        vectors++; if (rdata0 !== 32'hA000_0002) begin miscompares++; $display("[TB] FAIL simul_rdata0: got %h expected a0000002", rdata0); end
        req0 = 1'b0;
        @(posedge clk); #1;
        vectors++; if (mem_end !== 10'd3) begin miscompares++; $display("[TB] FAIL simul_second_grant: got addr %0d expected 3", mem_end); end
        vectors++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_gap_acks: got %b%b expected 00", ack1, ack0); end
        @(posedge clk); #1;
        vectors++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_ack1: got ack1/ack0 %b%b expected 10", ack1, ack0); end
        vectors++; if (rdata1 !== 32'hA000_0003) begin miscompares++; $display("[TB] FAIL simul_rdata1: got %h expected a0000003", rdata1); end
        req1 = 1'b0;
        @(posedge clk); #1;
        vectors++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_end_acks: got %b%b expected 00", ack1, ack0); end
    endtask

    task automatic test_stream();
        int          cnt0;
        int          cnt1;
        logic        exp0;
        logic        exp1;
        logic [31:0] exp_data;
        cnt0 = 0;
        cnt1 = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd20;
        // Grants on odd cycles alternate 0,1,...; acks land on even cycles.
        for (int n = 1; n <= 33; n++) begin
            @(posedge clk); #1;
            exp0 = (n % 4 == 2);
            exp1 = (n % 4 == 0);
            vectors++; if (ack0 !== exp0) begin miscompares++; $display("[TB] FAIL stream_ack0 cycle %0d: got %b expected %b", n, ack0, exp0); end
            vectors++; if (ack1 !== exp1) begin miscompares++; $display("[TB] FAIL stream_ack1 cycle %0d: got %b expected %b", n, ack1, exp1); end
            if (n <= 31 && n % 4 == 1) begin
                vectors++; if (mem_end !== 10'(10 + cnt0)) begin miscompares++; $display("[TB] FAIL stream_grant0 cycle %0d: got addr %0d expected %0d", n, mem_end, 10 + cnt0); end
            end
            if (n <= 31 && n % 4 == 3) begin
                vectors++; if (mem_end !== 10'(20 + cnt1)) begin miscompares++; $display("[TB] FAIL stream_grant1 cycle %0d: got addr %0d expected %0d", n, mem_end, 20 + cnt1); end
            end
            if (ack0 === 1'b1) begin
                exp_data = 32'hA000_0000 + 32'(10 + cnt0);
                vectors++; if (rdata0 !== exp_data) begin miscompares++; $display("[TB] FAIL stream_rdata0 cycle %0d: got %h expected %h", n, rdata0, exp_data); end
                cnt0++;
                addr0 = 10'(10 + cnt0);
                if (cnt0 == 8) req0 = 1'b0;
            end
            if (ack1 === 1'b1) begin
                exp_data = 32'hA000_0000 + 32'(20 + cnt1);
                vectors++; if (rdata1 !== exp_data) begin miscompares++; $display("[TB] FAIL stream_rdata1 cycle %0d: got %h expected %h", n, rdata1, exp_data); end
                cnt1++;
                addr1 = 10'(20 + cnt1);
                if (cnt1 == 8) req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd100; wdata0 = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        vectors++; if (mem_write !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_mem_write: got %b expected 1", mem_write); end
        vectors++; if (mem_end !== 10'd100) begin miscompares++; $display("[TB] FAIL wr_mem_end: got %0d expected 100", mem_end); end
        vectors++; if (mem_dado !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL wr_mem_dado: got %h expected deadbeef", mem_dado); end
        vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_early_ack: got %b expected 0", ack0); end
        @(posedge clk); #1;
        vectors++; if (ack0 !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_ack0: got %b expected 1", ack0); end
        vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_write_drop: got %b expected 0", mem_write); end
        req0 = 1'b0; we0 = 1'b0;
        @(posedge clk); #1;
        vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_ack_pulse: got %b expected 0", ack0); end
        vectors++; if (ram[100] !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL wr_ram100: got %h expected deadbeef", ram[100]); end

        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd100;
        @(posedge clk); #1;
        vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_mem_write: got %b expected 0", mem_write); end
        vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_early_ack: got %b expected 0", ack0); end
        @(posedge clk); #1;
        vectors++; if (ack0 !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_ack0: got %b expected 1", ack0); end
        vectors++; if (rdata0 !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd_rdata0: got %h expected deadbeef", rdata0); end
        req0 = 1'b0;
        @(posedge clk); #1;
        vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_ack_pulse: got %b expected 0", ack0); end
        vectors++; if (rdata0 !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd_rdata0_hold: got %h expected deadbeef", rdata0); end
    endtask

    task automatic test_raw();
        int wr_cycles;
        wr_cycles = 0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 10'd7; wdata1 = 32'h0000_1234;
        @(posedge clk); #1;
        if (mem_write === 1'b1) wr_cycles++;
        vectors++; if (mem_end !== 10'd7) begin miscompares++; $display("[TB] FAIL raw_wr_addr: got %0d expected 7", mem_end); end
        vectors++; if (mem_dado !== 32'h0000_1234) begin miscompares++; $display("[TB] FAIL raw_wr_data: got %h expected 00001234", mem_dado); end
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd7;
        @(posedge clk); #1;
        if (mem_write === 1'b1) wr_cycles++;
        vectors++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL raw_ack1: got ack1/ack0 %b%b expected 10", ack1, ack0); end
        req1 = 1'b0; we1 = 1'b0;
        @(posedge clk); #1;
        if (mem_write === 1'b1) wr_cycles++;
        vectors++; if (mem_end !== 10'd7 || ack1 !== 1'b0) begin miscompares++; $display("[TB] FAIL raw_rd_grant: got addr %0d ack1 %b expected addr 7 ack1 0", mem_end, ack1); end
        @(posedge clk); #1;
        if (mem_write === 1'b1) wr_cycles++;
        vectors++; if (ack0 !== 1'b1) begin miscompares++; $display("[TB] FAIL raw_ack0: got %b expected 1", ack0); end
        vectors++; if (rdata0 !== 32'h0000_1234) begin miscompares++; $display("[TB] FAIL raw_rdata0: got %h expected 00001234", rdata0); end
        req0 = 1'b0;
        @(posedge clk); #1;
        if (mem_write === 1'b1) wr_cycles++;
        vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("[TB] FAIL raw_end_ack0: got %b expected 0", ack0); end
        vectors++; if (wr_cycles != 1) begin miscompares++; $display("[TB] FAIL raw_write_cycles: got %0d expected 1", wr_cycles); end
        vectors++; if (ram[7] !== 32'h0000_1234) begin miscompares++; $display("[TB] FAIL raw_ram7: got %h expected 00001234", ram[7]); end
    endtask

    task automatic test_fixed_pri();
        int          cnt0;
        int          cnt1;
        logic        exp0;
        logic        exp1;
        logic [31:0] exp_data;
        cnt0 = 0;
        cnt1 = 0;
        fp_req0 = 1'b1; fp_addr0 = 10'd30;
        fp_req1 = 1'b1; fp_addr1 = 10'd40;
        // Port 1 still gets every other slot; once it leaves, port 0 cycles every 3 clocks.
        for (int n = 1; n <= 22; n++) begin
            @(posedge clk); #1;
            exp0 = (n inside {2, 6, 10, 14, 17, 20});
            exp1 = (n inside {4, 8, 12});
            vectors++; if (fp_ack0 !== exp0) begin miscompares++; $display("[TB] FAIL fixed_ack0 cycle %0d: got %b expected %b", n, fp_ack0, exp0); end
            vectors++; if (fp_ack1 !== exp1) begin miscompares++; $display("[TB] FAIL fixed_ack1 cycle %0d: got %b expected %b", n, fp_ack1, exp1); end
            if (fp_ack0 === 1'b1) begin
                exp_data = 32'hA000_0000 + 32'(30 + cnt0);
                vectors++; if (fp_rdata0 !== exp_data) begin miscompares++; $display("[TB] FAIL fixed_rdata0 cycle %0d: got %h expected %h", n, fp_rdata0, exp_data); end
                cnt0++;
                fp_addr0 = 10'(30 + cnt0);
                if (cnt0 == 6) fp_req0 = 1'b0;
            end
            if (fp_ack1 === 1'b1) begin
                exp_data = 32'hA000_0000 + 32'(40 + cnt1);
                vectors++; if (fp_rdata1 !== exp_data) begin miscompares++; $display("[TB] FAIL fixed_rdata1 cycle %0d: got %h expected %h", n, fp_rdata1, exp_data); end
                cnt1++;
                fp_addr1 = 10'(40 + cnt1);
                if (cnt1 == 3) fp_req1 = 1'b0;
            end
        end

        // Port 0 was the last winner, yet fixed priority still hands it the contested grant.
        fp_req0 = 1'b1; fp_addr0 = 10'd50;
        fp_req1 = 1'b1; fp_addr1 = 10'd51;
        @(posedge clk); #1;
        vectors++; if (fp_mem_end !== 10'd50) begin miscompares++; $display("[TB] FAIL fixed_contest_grant: got addr %0d expected 50", fp_mem_end); end
        @(posedge clk); #1;
        vectors++; if (fp_ack0 !== 1'b1 || fp_rdata0 !== 32'hA000_0032) begin miscompares++; $display("[TB] FAIL fixed_contest_ack0: got ack %b data %h expected 1 a0000032", fp_ack0, fp_rdata0); end
        fp_req0 = 1'b0;
        @(posedge clk); #1;
        vectors++; if (fp_mem_end !== 10'd51) begin miscompares++; $display("[TB] FAIL fixed_contest_second: got addr %0d expected 51", fp_mem_end); end
        @(posedge clk); #1;
        vectors++; if (fp_ack1 !== 1'b1 || fp_rdata1 !== 32'hA000_0033) begin miscompares++; $display("[TB] FAIL fixed_contest_ack1: got ack %b data %h expected 1 a0000033", fp_ack1, fp_rdata1); end
        fp_req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        req0   = 1'b0; req1   = 1'b0;
        we0    = 1'b0; we1    = 1'b0;
        addr0  = '0;   addr1  = '0;
        wdata0 = '0;   wdata1 = '0;
        fp_req0   = 1'b0; fp_req1   = 1'b0;
        fp_we0    = 1'b0; fp_we1    = 1'b0;
        fp_addr0  = '0;   fp_addr1  = '0;
        fp_wdata0 = '0;   fp_wdata1 = '0;

        $display("[TB] mem_arbiter directed bench starting");
        test_reset();
        test_simultaneous();
        test_stream();
        test_write_read();
        test_raw();
        test_fixed_pri();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
